// File: rtl/mips_cpu_muldiv_seq.sv
// mips_cpu_muldiv_seq
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer that owns the HI/LO pair.
// Shift-add multiply and restoring divide run on unsigned magnitudes. Signs
// are applied in FIX, so the iteration datapath never deals with signs.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous, active-low reset
//   start, op    issue request (00 MULT, 01 MULTU, 10 DIV, 11 DIVU)
//   rs_content   multiplicand / dividend
//   rt_content   multiplier / divisor
//   mthi, mtlo   write wr_data into HI / LO (IDLE only)
//   wr_data      MTHI/MTLO data
//   abort        (only with MULDIV_ABORT_EN) drop the op in flight
//   busy, done   sequencing status
//   hi, lo       architectural HI/LO registers
//   dbg_state    current FSM state (0 IDLE, 1 ITER, 2 FIX)
//
// Handshake: start is sampled only while busy=0. An accepted op raises busy
// from the next cycle. busy stays high until the edge that writes hi/lo.
// done pulses for the single cycle after that edge. Requests made while busy
// are dropped, not queued.
//
// Optional macro: MULDIV_ABORT_EN adds the abort input.
module mips_cpu_muldiv_seq #(
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] rs_content,
  input  logic [31:0] rt_content,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic [31:0] wr_data,
`ifdef MULDIV_ABORT_EN
  input  logic        abort,
`endif
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [1:0]  dbg_state
);

  localparam int N  = 32 / BITS_PER_CYCLE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ITER = 2'd1, S_FIX = 2'd2} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          is_div, is_signed, neg_a, neg_b;
  logic          div_zero, fix_wait;
  logic [31:0]   b_mag;
  // Multiply: {acc,q} is the product/multiplier shift pair.
  // Divide: acc is the partial remainder and q is the dividend/quotient.
  logic [31:0]   acc, q;

  logic [31:0]   a_mag_in, b_mag_in;
  logic [31:0]   acc_n, q_n;
  logic [31:0]   res_hi, res_lo;
  logic          abort_hit;

`ifdef MULDIV_ABORT_EN
  assign abort_hit = abort && (state != S_IDLE);
`else
  assign abort_hit = 1'b0;
`endif

  assign dbg_state = state;

  // Signed ops (op[0]=0) work on magnitudes.
  always_comb begin
    a_mag_in = (!op[0] && rs_content[31]) ? (32'd0 - rs_content) : rs_content;
    b_mag_in = (!op[0] && rt_content[31]) ? (32'd0 - rt_content) : rt_content;
  end

  // One iteration cycle retires BITS_PER_CYCLE bits.
  always_comb begin
    logic [32:0] t;
    acc_n = acc;
    q_n   = q;
    t     = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      if (is_div) begin
        t   = {acc_n, q_n[31]};
        q_n = {q_n[30:0], 1'b0};
        if (t >= {1'b0, b_mag}) begin
          t      = t - {1'b0, b_mag};
          q_n[0] = 1'b1;
        end
        acc_n = t[31:0];
      end else begin
        t     = {1'b0, acc_n} + (q_n[0] ? {1'b0, b_mag} : 33'd0);
        q_n   = {t[0], q_n[31:1]};
        acc_n = t[32:1];
      end
    end
  end

  // Sign correction. neg_a and neg_b are only set for signed ops.
  always_comb begin
    logic [63:0] prod;
    prod = {acc, q};
    if (neg_a ^ neg_b) prod = 64'd0 - prod;
    if (div_zero) begin
      // q still holds the dividend magnitude, so this restores rs_content.
      res_hi = neg_a ? (32'd0 - q) : q;
      res_lo = 32'hFFFF_FFFF;
    end else if (is_div) begin
      res_hi = neg_a ? (32'd0 - acc) : acc;
      res_lo = (neg_a ^ neg_b) ? (32'd0 - q) : q;
    end else begin
      res_hi = prod[63:32];
      res_lo = prod[31:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      is_div    <= 1'b0;
      is_signed <= 1'b0;
      neg_a     <= 1'b0;
      neg_b     <= 1'b0;
      div_zero  <= 1'b0;
      fix_wait  <= 1'b0;
      b_mag     <= '0;
      acc       <= '0;
      q         <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      hi        <= '0;
      lo        <= '0;
    end else begin
      done <= 1'b0;
      if (abort_hit) begin
        state    <= S_IDLE;
        busy     <= 1'b0;
        cnt      <= '0;
        div_zero <= 1'b0;
        fix_wait <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              is_div    <= op[1];
              is_signed <= ~op[0];
              neg_a     <= ~op[0] & rs_content[31];
              neg_b     <= ~op[0] & rt_content[31];
              b_mag     <= b_mag_in;
              acc       <= '0;
              q         <= a_mag_in;
              cnt       <= '0;
              busy      <= 1'b1;
              if (op[1] && (rt_content == 32'd0)) begin
                // Divide by zero skips the iterations but still takes two
                // busy cycles; fix_wait supplies the extra one.
                div_zero <= 1'b1;
                fix_wait <= 1'b1;
                state    <= S_FIX;
              end else begin
                state <= S_ITER;
              end
            end else begin
              if (mthi) hi <= wr_data;
              if (mtlo) lo <= wr_data;
            end
          end
          S_ITER: begin
            acc <= acc_n;
            q   <= q_n;
            if (cnt == CW'(N - 1)) begin
              cnt   <= '0;
              state <= S_FIX;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          S_FIX: begin
            if (fix_wait) begin
              fix_wait <= 1'b0;
            end else begin
              hi       <= res_hi;
              lo       <= res_lo;
              busy     <= 1'b0;
              done     <= 1'b1;
              div_zero <= 1'b0;
              state    <= S_IDLE;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  // is_signed is folded into neg_a/neg_b. It is kept as a readable record of
  // the latched op.
  logic unused_ok;
  assign unused_ok = is_signed;

endmodule
